pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register for the Minisys-1A pipeline. It is the generalised successor of the fixed per-stage latches.
- Carries one packed control field, one data field and an exception vector between two stages.
- Uses a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush and priority-encoded exception reporting.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_stage_buf.sv | 70 +++++++
 tb/tb_pipe_stage_buf.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with optional skid entry, flush and exception encoding
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 24,
  parameter int EXC_W = 8,
  parameter int SKID = 1,
  localparam int IDX_W = (EXC_W > 1) ? $clog2(EXC_W) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_exc_any,
  output logic [IDX_W-1:0]  out_exc_idx,
  output logic [1:0]        count
);
  localparam int E_W = CTRL_W + DATA_W + EXC_W;
  logic [E_W-1:0] main_q, skid_q, in_e;
  logic skid_valid, acc, drn;
  assign in_e = {in_ctrl, in_data, in_exc};
  assign {out_ctrl, out_data, out_exc} = main_q;
  // skid_valid is a flop, so the SKID=1 in_ready has no path from out_ready
  assign in_ready = (SKID != 0) ? !skid_valid : (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;
  assign count = 2'(out_valid) + 2'(skid_valid);
  assign out_exc_any = out_valid && |out_exc;
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (!out_valid) begin
      if (acc) begin
        main_q <= in_e;
        out_valid <= 1'b1;
      end
    end else if (skid_valid) begin
      if (drn) begin
        main_q <= skid_q;
        skid_q <= '0;
        skid_valid <= 1'b0;
      end
    end else if (acc && !drn) begin
      skid_q <= in_e;
      skid_valid <= 1'b1;
    end else if (acc) begin
      main_q <= in_e;
    end else if (drn) begin
      main_q <= '0;
      out_valid <= 1'b0;
    end
  end
  // lowest set bit wins, so scan downward and let the last hit stand
  always_comb begin
    out_exc_idx = '0;
    for (int i = EXC_W - 1; i >= 0; i--)
      if (out_exc[i]) out_exc_idx = IDX_W'(i);
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed checks of pipe_stage_buf with SKID=1 and SKID=0 instances
module tb_pipe_stage_buf;
  logic clock = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [23:0] in_ctrl;
  logic [31:0] in_data;
  logic [7:0] in_exc;
  logic in_ready, out_valid, out_exc_any;
  logic [23:0] out_ctrl;
  logic [31:0] out_data;
  logic [7:0] out_exc;
  logic [2:0] out_exc_idx;
  logic [1:0] count;
  logic r0_in_ready, r0_out_valid, r0_out_exc_any;
  logic [23:0] r0_out_ctrl;
  logic [31:0] r0_out_data;
  logic [7:0] r0_out_exc;
  logic [2:0] r0_out_exc_idx;
  logic [1:0] r0_count;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_stage_buf #(.SKID(1)) u_dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .out_exc(out_exc),
    .out_exc_any(out_exc_any), .out_exc_idx(out_exc_idx), .count(count)
  );

  pipe_stage_buf #(.SKID(0)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r0_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc), .out_valid(r0_out_valid),
    .out_ready(out_ready), .out_ctrl(r0_out_ctrl), .out_data(r0_out_data), .out_exc(r0_out_exc),
    .out_exc_any(r0_out_exc_any), .out_exc_idx(r0_out_exc_idx), .count(r0_count)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_ctrl = 24'h123456; in_data = 32'h5; in_exc = 8'h01;
    tick; tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_ctrl !== 24'h0) begin errors++; $display("FAIL reset_out_ctrl: got %h expected 0", out_ctrl); end
    reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_exc = '0; in_data = '0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 32'(k);
      tick;
      checks++; if (out_data !== 32'(k)) begin errors++; $display("FAIL stream_data%0d: got %h expected %h", k, out_data, k); end
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL stream_count%0d: got %0d expected 1", k, count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d: got %b expected 1", k, in_ready); end
    end
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL stream_bubble_data: got %h expected 0", out_data); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL bp_count1: got %0d expected 1", count); end
    in_data = 32'hB;
    tick;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL bp_count2: got %0d expected 2", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
    checks++; if (out_data !== 32'hA) begin errors++; $display("FAIL bp_head_a: got %h expected a", out_data); end
    in_data = 32'hC;
    tick;
    checks++; if (out_data !== 32'hA || count !== 2'd2) begin errors++; $display("FAIL bp_hold: got %h/%0d expected a/2", out_data, count); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_data !== 32'hB) begin errors++; $display("FAIL bp_second_b: got %h expected b", out_data); end
    checks++; if (in_ready !== 1'b1 || count !== 2'd1) begin errors++; $display("FAIL bp_reopen: got %b/%0d expected 1/1", in_ready, count); end
    tick;
    checks++; if (out_data !== 32'hC) begin errors++; $display("FAIL bp_third_c: got %h expected c", out_data); end
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL bp_empty: got %b/%0d expected 0/0", out_valid, count); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 24'hFFFFFF; in_exc = 8'h80; in_data = 32'hA;
    tick;
    in_data = 32'hB;
    tick;
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d expected 2", count); end
    flush = 1'b1; in_data = 32'hD;
    tick;
    checks++; if (out_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL flush_state: got %b/%0d expected 0/0", out_valid, count); end
    checks++; if (out_data !== 32'h0 || out_ctrl !== 24'h0 || out_exc !== 8'h0) begin errors++; $display("FAIL flush_fields: got %h/%h/%h expected 0/0/0", out_ctrl, out_data, out_exc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_ctrl = '0; in_exc = '0;
    tick;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL flush_no_d: got %b/%h expected 0/0", out_valid, out_data); end
  endtask

  task automatic test_exc;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 24'hABCDEF; in_exc = 8'b0010_0100;
    tick;
    checks++; if (out_exc_any !== 1'b1 || out_exc_idx !== 3'd2) begin errors++; $display("FAIL exc_24: got %b/%0d expected 1/2", out_exc_any, out_exc_idx); end
    checks++; if (out_ctrl !== 24'hABCDEF || out_exc !== 8'h24) begin errors++; $display("FAIL exc_fields: got %h/%h expected abcdef/24", out_ctrl, out_exc); end
    in_exc = 8'h00;
    tick;
    checks++; if (out_exc_any !== 1'b0 || out_exc_idx !== 3'd0) begin errors++; $display("FAIL exc_none: got %b/%0d expected 0/0", out_exc_any, out_exc_idx); end
    in_exc = 8'h80;
    tick;
    checks++; if (out_exc_any !== 1'b1 || out_exc_idx !== 3'd7) begin errors++; $display("FAIL exc_80: got %b/%0d expected 1/7", out_exc_any, out_exc_idx); end
    in_valid = 1'b0; in_exc = 8'h00; in_ctrl = '0;
    tick;
    checks++; if (out_exc_any !== 1'b0 || out_exc !== 8'h0 || out_ctrl !== 24'h0) begin errors++; $display("FAIL exc_bubble: got %b/%h/%h expected 0/0/0", out_exc_any, out_exc, out_ctrl); end
  endtask

  task automatic test_skid0_reset;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h11;
    checks++; if (r0_in_ready !== 1'b1) begin errors++; $display("FAIL s0_ready_empty: got %b expected 1", r0_in_ready); end
    tick;
    checks++; if (r0_out_valid !== 1'b1 || r0_out_data !== 32'h11 || r0_count !== 2'd1) begin errors++; $display("FAIL s0_load: got %b/%h/%0d expected 1/11/1", r0_out_valid, r0_out_data, r0_count); end
    checks++; if (r0_in_ready !== 1'b0) begin errors++; $display("FAIL s0_ready_full: got %b expected 0", r0_in_ready); end
    in_data = 32'h22;
    tick;
    checks++; if (r0_out_data !== 32'h11 || r0_count !== 2'd1) begin errors++; $display("FAIL s0_hold: got %h/%0d expected 11/1", r0_out_data, r0_count); end
    out_ready = 1'b1;
    #1;
    checks++; if (r0_in_ready !== 1'b1) begin errors++; $display("FAIL s0_ready_comb: got %b expected 1", r0_in_ready); end
    tick;
    checks++; if (r0_out_data !== 32'h22 || r0_count !== 2'd1) begin errors++; $display("FAIL s0_pass: got %h/%0d expected 22/1", r0_out_data, r0_count); end
    out_ready = 1'b0; in_data = 32'h33;
    tick;
    reset = 1'b0; flush = 1'b1;
    tick;
    checks++; if (r0_out_valid !== 1'b0 || r0_count !== 2'd0 || r0_out_data !== 32'h0 || r0_out_exc_any !== 1'b0) begin errors++; $display("FAIL s0_reset_flush: got %b/%0d/%h expected 0/0/0", r0_out_valid, r0_count, r0_out_data); end
    checks++; if (out_valid !== 1'b0 || count !== 2'd0 || out_data !== 32'h0 || out_ctrl !== 24'h0) begin errors++; $display("FAIL s1_reset_flush: got %b/%0d/%h expected 0/0/0", out_valid, count, out_data); end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_exc;
    test_skid0_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
